// File: rtl/uart_rx_core_pkg.sv
// uart_rx_core_pkg: shared types and sizes
// for the UART receive path.
package uart_rx_core_pkg;

  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_PTR_W  = 4;
  localparam int FIFO_CNT_W  = 5;
  localparam int REC_WIDTH   = 11;

  localparam int RX_ENTRY_FE = 0;
  localparam int RX_ENTRY_PE = 1;
  localparam int RX_ENTRY_BI = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    PUSH,
    BRK_WAIT
  } rx_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       bi;
    logic       pe;
    logic       fe;
  } rx_entry_t;

  // Expected parity bit: stick, even or odd.
  function automatic logic par_expect(
    input logic       sp,
    input logic       ep,
    input logic [7:0] d
  );
    if (sp) return ~ep;
    return ep ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead synchronous FIFO
// with flush; pop on empty is ignored.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int CNT_W = 5,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  // Pointer and occupancy update; flush wins.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = nxt(wr_q);
      if (do_pop)  rd_d = nxt(rd_q);
      if (do_push && !do_pop)
        cnt_d = cnt_q + CNT_W'(1);
      else if (!do_push && do_pop)
        cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART frame
// deserializer feeding the receive FIFO.
module uart_rx_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        rx_i,
  input  logic [7:0]  lcr_i,
  input  logic        fifo_clr_i,
  input  logic        pop_i,
  input  logic        ls_clr_i,
  output logic [10:0] rdata_o,
  output logic [4:0]  count_o,
  output logic        data_ready_o,
  output logic        overrun_o,
  output logic        rx_busy_o
);
  import uart_rx_core_pkg::*;

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  rx_state_t  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic [1:0] len_q, len_d;
  logic       pen_q, pen_d;
  logic       eps_q, eps_d;
  logic       sps_q, sps_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       par_q, par_d;
  logic       ovr_q, ovr_d;
  logic       rx_s, fall, mid, full_smp;
  logic       push, full, empty;
  rx_entry_t  entry;
  logic       unused_lcr;

  assign unused_lcr = ^{lcr_i[7:6], lcr_i[2]};
  assign rx_s      = sync_q[1];
  assign fall      = prev_q & ~rx_s;
  assign mid       = enable_i & (tick_q == 4'd7);
  assign full_smp  = enable_i & (tick_q == 4'd15);

  // Synchroniser and edge history.
  always_comb begin
    sync_d = {sync_q[0], rx_i};
    prev_d = rx_s;
  end

  // Frame sequencer: next state and datapath.
  always_comb begin
    state_d = state_q;
    tick_d  = enable_i ? tick_q + 4'd1 : tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    len_d   = len_q;
    pen_d   = pen_q;
    eps_d   = eps_q;
    sps_d   = sps_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    par_d   = par_q;
    push    = 1'b0;
    entry.data = data_q;
    entry.bi   = (data_q == 8'd0) & ~par_q & fe_q;
    entry.pe   = pe_q;
    entry.fe   = fe_q;
    unique case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        tick_d  = 4'd0;
        bit_d   = 3'd0;
        data_d  = 8'd0;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
        par_d   = 1'b0;
        len_d   = lcr_i[1:0];
        pen_d   = lcr_i[3];
        eps_d   = lcr_i[4];
        sps_d   = lcr_i[5];
      end
      START: if (mid) begin
        tick_d  = 4'd0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (full_smp) begin
        data_d[bit_q] = rx_s;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd4 + {1'b0, len_q})
          state_d = pen_q ? PARITY : STOP;
      end
      PARITY: if (full_smp) begin
        par_d   = rx_s;
        pe_d    = rx_s ^ par_expect(sps_q, eps_q, data_q);
        state_d = STOP;
      end
      STOP: if (full_smp) begin
        fe_d    = ~rx_s;
        state_d = PUSH;
      end
      PUSH: begin
        push    = 1'b1;
        state_d = entry.bi ? BRK_WAIT : IDLE;
      end
      BRK_WAIT: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky overrun: a set beats a clear.
  always_comb begin
    ovr_d = ovr_q;
    if (ls_clr_i) ovr_d = 1'b0;
    if (push && full && !pop_i) ovr_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      sps_q   <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      par_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      len_q   <= len_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
      sps_q   <= sps_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      par_q   <= par_d;
      ovr_q   <= ovr_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .PTR_W(FIFO_PTR_W),
    .CNT_W(FIFO_CNT_W),
    .WIDTH(REC_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (entry),
    .pop_i   (pop_i),
    .clr_i   (fifo_clr_i),
    .rdata_o (rdata_o),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign data_ready_o = ~empty;
  assign overrun_o    = ovr_q;
  assign rx_busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table vectors, corner
// sequences and random frames vs a queue model.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        rx_i = 1'b1;
  logic [7:0]  lcr_i = 8'h03;
  logic        fifo_clr_i = 1'b0;
  logic        pop_i = 1'b0;
  logic        ls_clr_i = 1'b0;
  logic [10:0] rdata_o;
  logic [4:0]  count_o;
  logic        data_ready_o;
  logic        overrun_o;
  logic        rx_busy_o;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  logic [10:0] mq[$];
  logic        m_ovr = 1'b0;

  typedef struct {
    logic [7:0]  lcr;
    logic [7:0]  d;
    logic        flip;
    logic        stop;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[10];

  uart_rx_core dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .rx_i         (rx_i),
    .lcr_i        (lcr_i),
    .fifo_clr_i   (fifo_clr_i),
    .pop_i        (pop_i),
    .ls_clr_i     (ls_clr_i),
    .rdata_o      (rdata_o),
    .count_o      (count_o),
    .data_ready_o (data_ready_o),
    .overrun_o    (overrun_o),
    .rx_busy_o    (rx_busy_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    en_cnt++;
    enable_i = (en_cnt % 3 == 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic par_bit(
    input logic [7:0] lcr, input logic [7:0] dm);
    if (lcr[5]) return ~lcr[4];
    return lcr[4] ? ^dm : ~^dm;
  endfunction

  function automatic logic [7:0] dmask(
    input logic [7:0] lcr, input logic [7:0] d);
    int nb;
    nb = 5 + int'(lcr[1:0]);
    return d & (8'hFF >> (8 - nb));
  endfunction

  function automatic logic [10:0] ref_entry(
    input logic [7:0] lcr, input logic [7:0] d,
    input logic flip, input logic stop);
    logic [7:0] dm;
    logic pb, pe, bi;
    dm = dmask(lcr, d);
    pb = par_bit(lcr, dm) ^ flip;
    pe = lcr[3] & flip;
    bi = (dm == 8'd0) && (!lcr[3] || !pb) && !stop;
    return {dm, bi, pe, ~stop};
  endfunction

  function automatic void model_push(
    input logic [10:0] e, input logic popping);
    if (mq.size() == 16) begin
      if (popping) begin
        void'(mq.pop_front());
        mq.push_back(e);
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      if (popping && mq.size() > 0)
        void'(mq.pop_front());
      mq.push_back(e);
    end
  endfunction

  task automatic check_state(input string tag);
    logic [10:0] h;
    h = (mq.size() > 0) ? mq[0] : 11'h000;
    chk({tag, "_cnt"}, 32'(count_o), mq.size());
    chk({tag, "_head"}, 32'(rdata_o), 32'(h));
    chk({tag, "_rdy"}, 32'(data_ready_o),
        32'(mq.size() > 0));
    chk({tag, "_ovr"}, 32'(overrun_o), 32'(m_ovr));
    chk({tag, "_busy"}, 32'(rx_busy_o), 0);
  endtask

  task automatic align();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!enable_i && n < 10);
  endtask

  task automatic do_pop();
    pop_i = 1'b1;
    cyc();
    pop_i = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic send(input logic [7:0] lcr,
                      input logic [7:0] d,
                      input logic flip,
                      input logic stop,
                      input logic pop_at_push);
    logic [11:0] bits;
    logic [7:0]  dm;
    logic        was_empty;
    int nb, nt, k;
    lcr_i = lcr;
    dm = dmask(lcr, d);
    nb = 5 + int'(lcr[1:0]);
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < nb; i++) bits[1+i] = dm[i];
    nt = 1 + nb;
    if (lcr[3]) begin
      bits[nt] = par_bit(lcr, dm) ^ flip;
      nt++;
    end
    bits[nt] = stop;
    nt++;
    k = 8 + 16 * (nt - 1);
    align();
    was_empty = (mq.size() == 0);
    for (int c = 0; c < 48 * nt; c++) begin
      rx_i  = bits[c / 48];
      pop_i = pop_at_push && (c == 3 * k + 1);
      if (was_empty && c == 3 * k + 1)
        chk("lat_pre", 32'(data_ready_o), 0);
      if (was_empty && c == 3 * k + 2)
        chk("lat_post", 32'(data_ready_o), 1);
      cyc();
    end
    pop_i = 1'b0;
    rx_i  = 1'b1;
    model_push(ref_entry(lcr, d, flip, stop),
               pop_at_push);
    repeat (48) cyc();
  endtask

  initial begin
    tbl[0] = '{8'h03, 8'hA5, 1'b0, 1'b1, 11'h528};
    tbl[1] = '{8'h1B, 8'h03, 1'b1, 1'b1, 11'h01A};
    tbl[2] = '{8'h1B, 8'h03, 1'b0, 1'b1, 11'h018};
    tbl[3] = '{8'h03, 8'h55, 1'b0, 1'b0, 11'h2A9};
    tbl[4] = '{8'h00, 8'h1F, 1'b0, 1'b1, 11'h0F8};
    tbl[5] = '{8'h0B, 8'h03, 1'b0, 1'b1, 11'h018};
    tbl[6] = '{8'h0B, 8'h07, 1'b1, 1'b1, 11'h03A};
    tbl[7] = '{8'h02, 8'hFF, 1'b0, 1'b1, 11'h3F8};
    tbl[8] = '{8'h3B, 8'h81, 1'b1, 1'b1, 11'h40A};
    tbl[9] = '{8'h01, 8'hC0, 1'b0, 1'b1, 11'h000};

    rst = 1'b1;
    repeat (3) cyc();
    check_state("reset");
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].lcr, tbl[i].d, tbl[i].flip,
           tbl[i].stop, 1'b0);
      chk("tbl_entry", 32'(rdata_o), 32'(tbl[i].exp));
      chk("tbl_cnt", 32'(count_o), 1);
      chk("tbl_rdy", 32'(data_ready_o), 1);
      do_pop();
      chk("tbl_popcnt", 32'(count_o), 0);
    end

    // Held-low line: one break entry only.
    lcr_i = 8'h03;
    align();
    rx_i = 1'b0;
    repeat (3 * 480) cyc();
    chk("brk_busy", 32'(rx_busy_o), 1);
    chk("brk_one", 32'(count_o), 1);
    rx_i = 1'b1;
    repeat (96) cyc();
    chk("brk_entry", 32'(rdata_o), 32'h005);
    mq.push_back(11'h005);
    check_state("brk");
    send(8'h03, 8'h3C, 1'b0, 1'b1, 1'b0);
    check_state("brk_next");
    do_pop();
    chk("brk_next_entry", 32'(rdata_o), 32'h1E0);
    do_pop();

    // Fill past full.
    for (int i = 0; i < 17; i++)
      send(8'h03, 8'(8'h10 + i), 1'b0, 1'b1, 1'b0);
    chk("full_cnt", 32'(count_o), 16);
    chk("full_ovr", 32'(overrun_o), 1);
    chk("full_head", 32'(rdata_o), 32'h080);
    check_state("full");
    ls_clr_i = 1'b1;
    cyc();
    ls_clr_i = 1'b0;
    m_ovr = 1'b0;
    chk("ovr_clr", 32'(overrun_o), 0);
    send(8'h03, 8'h40, 1'b0, 1'b1, 1'b1);
    chk("pp_ovr", 32'(overrun_o), 0);
    chk("pp_cnt", 32'(count_o), 16);
    chk("pp_head", 32'(rdata_o), 32'h088);
    check_state("pushpop");
    send(8'h03, 8'h41, 1'b0, 1'b1, 1'b0);
    fifo_clr_i = 1'b1;
    cyc();
    fifo_clr_i = 1'b0;
    mq.delete();
    chk("clr_cnt", 32'(count_o), 0);
    chk("clr_ovr", 32'(overrun_o), 1);
    check_state("clr");
    ls_clr_i = 1'b1;
    cyc();
    ls_clr_i = 1'b0;
    m_ovr = 1'b0;
    do_pop();
    check_state("pop_empty");

    // Short low glitch.
    align();
    rx_i = 1'b0;
    repeat (12) cyc();
    rx_i = 1'b1;
    repeat (96) cyc();
    check_state("glitch");

    // Reset in the middle of DATA.
    send(8'h03, 8'h77, 1'b0, 1'b1, 1'b0);
    align();
    for (int c = 0; c < 48 * 4; c++) begin
      rx_i = (c < 48) ? 1'b0 : 1'((c / 48) % 2);
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rx_i = 1'b1;
    mq.delete();
    m_ovr = 1'b0;
    check_state("midrst");
    repeat (48) cyc();
    send(8'h03, 8'h5A, 1'b0, 1'b1, 1'b0);
    chk("midrst_next", 32'(rdata_o), 32'h2D0);
    do_pop();

    // Random frames against the model.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] lcr, d;
      logic flip, stop;
      int np;
      lcr  = 8'($urandom);
      d    = ($urandom_range(0, 7) == 0)
             ? 8'h00 : 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      send(lcr, d, flip, stop, 1'b0);
      check_state("rnd");
      np = $urandom_range(0, 2);
      repeat (np) do_pop();
    end
    while (mq.size() > 0) begin
      check_state("drain");
      do_pop();
    end
    check_state("end");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
